// File: rtl/pb_led_sequencer_pkg.sv
// pb_led_pkg: shared types and constants for the LogiPi pushbutton/LED
// sequencer.
//   mode_e        : LED pattern mode, 2-bit encoding (also driven on MODE)
//   SPEED_MAX     : highest speed code; the next speed step wraps to 0
//   PWM_ON_THRESH : PWM count below which a dimmed LED is lit
//                   (used only when PB_LED_DIM_EN is defined)
//   div_last()    : last tick-divider count for a speed, i.e. (1<<speed)-1
package pb_led_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    MIRROR = 2'd1,
    BLINK  = 2'd2,
    ALT    = 2'd3
  } mode_e;

  localparam logic [1:0] SPEED_MAX     = 2'd2;
  localparam logic [3:0] PWM_ON_THRESH = 4'd4;

  function automatic logic [1:0] div_last(input logic [1:0] speed);
    case (speed)
      2'd0:    div_last = 2'd0;
      2'd1:    div_last = 2'd1;
      default: div_last = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/pb_led_sequencer_debounce.sv
// pb_debounce: 2-flop synchroniser plus counter debounce for one
// active-low pushbutton.
//   CLK    : clock
//   RST_n  : asynchronous active-low reset
//   pb_n   : raw button pin, active low, asynchronous to CLK
//   level  : accepted (debounced) level, active high = pressed
//   press  : one-cycle pulse on each accepted released->pressed change
// Pin edge to press pulse is 2 + DB_CYCLES cycles.
module pb_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic pb_n,
  output logic level,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          r_sync1, r_sync2;
  logic          r_level, r_press;
  logic [CW-1:0] r_cnt;
  logic          w_pressed;

  assign w_pressed = ~r_sync2;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= pb_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      // Any cycle agreeing with the accepted level restarts the count, so
      // only an unbroken run of DB_CYCLES disagreeing cycles flips it.
      if (w_pressed == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= w_pressed;
        r_press <= w_pressed;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/pb_led_sequencer.sv
// pb_led_sequencer: debounces two pushbuttons and sequences two LEDs
// through OFF / MIRROR / BLINK / ALT patterns at three blink speeds.
//   CLK   : clock, rising edge
//   RST_n : asynchronous active-low reset
//   PB0_n : mode button, active low (press advances the mode)
//   PB1_n : speed button, active low (press steps speed in BLINK/ALT)
//   LED0  : LED 0, active high, registered
//   LED1  : LED 1, active high, registered
//   MODE  : current mode, registered
// Build option PB_LED_DIM_EN: lit BLINK/ALT LEDs run at 25% PWM duty.
module pb_led_sequencer
  import pb_led_pkg::*;
#(
  parameter int DB_CYCLES   = 500000,
  parameter int TICK_CYCLES = 12500000
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       PB0_n,
  input  logic       PB1_n,
  output logic       LED0,
  output logic       LED1,
  output logic [1:0] MODE
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  logic          w_lvl0, w_lvl1, w_prs0, w_prs1;
  mode_e         r_mode, w_mode_nxt;
  logic [1:0]    r_speed, w_speed_nxt;
  logic          w_clr;
  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;
  logic [1:0]    r_div;
  logic          r_phase;
  logic          r_led0, r_led1;
  logic          w_on;

  pb_debounce #(.DB_CYCLES(DB_CYCLES)) u_db0 (
    .CLK(CLK), .RST_n(RST_n), .pb_n(PB0_n), .level(w_lvl0), .press(w_prs0)
  );

  pb_debounce #(.DB_CYCLES(DB_CYCLES)) u_db1 (
    .CLK(CLK), .RST_n(RST_n), .pb_n(PB1_n), .level(w_lvl1), .press(w_prs1)
  );

  // Mode/speed state register
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_mode  <= OFF;
      r_speed <= 2'd0;
    end else begin
      r_mode  <= w_mode_nxt;
      r_speed <= w_speed_nxt;
    end
  end

  // Mode press wins over a same-cycle speed press. Every mode or speed
  // change restarts the blink timebase so the new pattern starts clean.
  always_comb begin
    w_mode_nxt  = r_mode;
    w_speed_nxt = r_speed;
    w_clr       = 1'b0;
    if (w_prs0) begin
      w_clr = 1'b1;
      case (r_mode)
        OFF:     w_mode_nxt = MIRROR;
        MIRROR:  w_mode_nxt = BLINK;
        BLINK:   w_mode_nxt = ALT;
        default: w_mode_nxt = OFF;
      endcase
    end else if (w_prs1 && (r_mode == BLINK || r_mode == ALT)) begin
      w_clr       = 1'b1;
      w_speed_nxt = (r_speed == SPEED_MAX) ? 2'd0 : r_speed + 2'd1;
    end
  end

  assign w_tick = (r_tick_cnt == TICK_LAST);

  // Base tick, divider by 2^speed, and blink phase
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_tick_cnt <= '0;
      r_div      <= 2'd0;
      r_phase    <= 1'b0;
    end else if (w_clr) begin
      r_tick_cnt <= '0;
      r_div      <= 2'd0;
      r_phase    <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      if (w_tick) begin
        if (r_div == div_last(r_speed)) begin
          r_div   <= 2'd0;
          r_phase <= ~r_phase;
        end else begin
          r_div <= r_div + 2'd1;
        end
      end
    end
  end

`ifdef PB_LED_DIM_EN
  logic [3:0] r_pwm;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) r_pwm <= 4'd0;
    else        r_pwm <= r_pwm + 4'd1;
  end

  assign w_on = (r_pwm < PWM_ON_THRESH);
`else
  assign w_on = 1'b1;
`endif

  // LED pattern register
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_led0 <= 1'b0;
      r_led1 <= 1'b0;
    end else begin
      case (r_mode)
        MIRROR: begin
          r_led0 <= w_lvl0;
          r_led1 <= w_lvl1;
        end
        BLINK: begin
          r_led0 <= r_phase & w_on;
          r_led1 <= r_phase & w_on;
        end
        ALT: begin
          r_led0 <= r_phase & w_on;
          r_led1 <= ~r_phase & w_on;
        end
        default: begin
          r_led0 <= 1'b0;
          r_led1 <= 1'b0;
        end
      endcase
    end
  end

  assign LED0 = r_led0;
  assign LED1 = r_led1;
  assign MODE = r_mode;

endmodule

// File: tb/tb_pb_led_sequencer.sv
// Directed bench for pb_led_sequencer with DB_CYCLES=4, TICK_CYCLES=8.
module tb_pb_led_sequencer;

  logic       CLK, RST_n, PB0_n, PB1_n;
  logic       LED0, LED1;
  logic [1:0] MODE;
  int         n_chk, n_err;

  pb_led_sequencer #(.DB_CYCLES(4), .TICK_CYCLES(8)) dut (
    .CLK(CLK), .RST_n(RST_n), .PB0_n(PB0_n), .PB1_n(PB1_n),
    .LED0(LED0), .LED1(LED1), .MODE(MODE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, act, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic press0();
    PB0_n = 1'b0; step(20);
    PB0_n = 1'b1; step(10);
  endtask

  task automatic press1();
    PB1_n = 1'b0; step(20);
    PB1_n = 1'b1; step(10);
  endtask

  // Length of one complete LED0 high run in cycles; -1 on timeout
  task automatic meas_hi(output int n);
    int g;
    g = 0;
    n = 0;
    while (LED0 === 1'b1 && g < 200) begin step(1); g++; end
    while (LED0 !== 1'b1 && g < 400) begin step(1); g++; end
    while (LED0 === 1'b1 && n < 200) begin step(1); n++; end
    if (g >= 400 || n >= 200) n = -1;
  endtask

  // Cycles over the next n where LED1 is not the inverse of LED0
  task automatic alt_bad(input int n, output int bad);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (LED1 !== ~LED0) bad++;
      step(1);
    end
  endtask

  initial begin
    int p, bad, hi, g;
    n_chk = 0; n_err = 0;
    RST_n = 1'b0; PB0_n = 1'b1; PB1_n = 1'b1;
    step(2);
    chk("rst_led0", LED0, 0);
    chk("rst_led1", LED1, 0);
    chk("rst_mode", MODE, 0);
    RST_n = 1'b1;
    step(3);

    // Debounce: short glitch ignored, then exact acceptance latency
    PB0_n = 1'b0; step(3); PB0_n = 1'b1; step(10);
    chk("glitch_mode", MODE, 0);
    PB0_n = 1'b0; step(6);
    chk("db_mode_e6", MODE, 0);
    step(1);
    chk("db_mode_e7", MODE, 1);
    step(13);
    chk("hold_mode", MODE, 1);
    chk("mirror_led0_held", LED0, 1);
    PB0_n = 1'b1; step(10);
    chk("release_mode", MODE, 1);
    chk("mirror_led0_rel", LED0, 0);

    // MIRROR on PB1: 2+4+1 cycles each way; speed must stay 0
    PB1_n = 1'b0; step(6);
    chk("mir_led1_e6", LED1, 0);
    step(1);
    chk("mir_led1_e7", LED1, 1);
    chk("mir_led0", LED0, 0);
    step(10);
    PB1_n = 1'b1; step(6);
    chk("mir_led1_rel_e6", LED1, 1);
    step(1);
    chk("mir_led1_rel_e7", LED1, 0);
    step(5);

    // BLINK speeds 0 -> 1 -> 2 -> 0
    press0();
    chk("blink_mode", MODE, 2);
    meas_hi(p); chk("blink_s0", p, 8);
    press1();
    meas_hi(p); chk("blink_s1", p, 16);
    press1();
    meas_hi(p); chk("blink_s2", p, 32);
    press1();
    meas_hi(p); chk("blink_wrap", p, 8);

    // Simultaneous presses: mode wins, speed untouched
    PB0_n = 1'b0; PB1_n = 1'b0; step(20);
    PB0_n = 1'b1; PB1_n = 1'b1; step(10);
    chk("sim_mode", MODE, 3);
    meas_hi(p); chk("alt_s0", p, 8);
    alt_bad(24, bad); chk("alt_compl_s0", bad, 0);

    // Speed step in ALT; duty over one full on-phase
    press1();
    chk("alt_mode_keep", MODE, 3);
    meas_hi(p); chk("alt_s1", p, 16);
    step(15);
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (LED0 === 1'b1) hi++;
    end
`ifdef PB_LED_DIM_EN
    chk("duty_on", hi, 4);
`else
    chk("duty_on", hi, 16);
`endif
    alt_bad(40, bad); chk("alt_compl_s1", bad, 0);

    // Wrap to OFF, then back to BLINK; speed persists across mode changes
    press0();
    chk("off_mode", MODE, 0);
    chk("off_led0", LED0, 0);
    chk("off_led1", LED1, 0);
    press0(); press0();
    chk("blink2_mode", MODE, 2);
    meas_hi(p); chk("blink_keep_s1", p, 16);

    // Reset mid-BLINK while LEDs are lit
    g = 0;
    while (LED0 !== 1'b1 && g < 100) begin step(1); g++; end
    chk("lit_before_rst", LED0, 1);
    RST_n = 1'b0; #2;
    chk("async_led0", LED0, 0);
    chk("async_led1", LED1, 0);
    chk("async_mode", MODE, 0);
    step(3);
    RST_n = 1'b1; step(40);
    chk("post_rst_mode", MODE, 0);
    chk("post_rst_led0", LED0, 0);
    chk("post_rst_led1", LED1, 0);
    press0();
    chk("post_rst_press", MODE, 1);
    press0();
    meas_hi(p); chk("post_rst_s0", p, 8);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pb_led_sequencer.md
Name: pb_led_sequencer

Overview:
Controller for the LogiPi pushbutton/LED pair. It debounces the two active-low pushbuttons and turns each press into a single-cycle event. The events drive a mode/speed state machine, which sequences LED0/LED1 through OFF, MIRROR, BLINK and ALTERNATE patterns. It sits between the board pins and the LEDs, and replaces the direct combinational button-to-LED path.

Parameters:
DB_CYCLES, 500000, consecutive stable cycles required to accept a button level change (10 ms at 50 MHz)
TICK_CYCLES, 12500000, base tick period in CLK cycles (4 Hz at 50 MHz)

Ports:
CLK  input  1  system clock, all logic on rising edge
RST_n  input  1  asynchronous active-low reset
PB0_n  input  1  pushbutton 0, active low, asynchronous to CLK (mode select)
PB1_n  input  1  pushbutton 1, active low, asynchronous to CLK (speed select)
LED0  output  1  LED 0, active high, registered
LED1  output  1  LED 1, active high, registered
MODE  output  2  current mode (debug), registered

Behaviour:
- Clocking and reset: one clock, CLK. Reset RST_n is asynchronous, active-low.
- Reset values: LED0=0, LED1=0, MODE=OFF(0), speed=0, phase=0, tick counter=0. Debounced levels reset to released; synchronisers reset to 1 (released).
- Synchronisation: each PBx_n passes through a 2-flop synchroniser, then is inverted to active-high.
- Debounce: a counter clears whenever the synced level equals the accepted level. Otherwise it increments.
  - When the counter reaches DB_CYCLES-1, the accepted level flips and the counter clears.
  - Press event (1 cycle) is raised on the accepted released-to-pressed transition only. Release raises no event.
  - Latency from pin edge to event: 2 + DB_CYCLES cycles. Glitches shorter than DB_CYCLES produce no event.
- Mode FSM: OFF(0) -> MIRROR(1) -> BLINK(2) -> ALT(3) -> OFF. It advances one step per PB0 press event.
- Speed: a 2-bit register with values 0,1,2. A PB1 press increments it, wrapping 2 -> 0.
  - Speed changes only in BLINK or ALT. PB1 presses in OFF or MIRROR leave speed unchanged.
- Simultaneous PB0 and PB1 events in the same cycle: mode advances and the PB1 event is discarded.
- Tick generator: a counter runs 0..TICK_CYCLES-1 and wraps, raising tick for one cycle at wrap.
  - A divider counts ticks. When it reaches (1<<speed)-1 it clears and phase toggles.
  - Phase half-period is therefore TICK_CYCLES*2^speed cycles.
- Any mode change or speed change clears the tick counter, the divider and phase in the same cycle.
- LED outputs, registered (one cycle after the state update):
  - OFF: 0,0
  - MIRROR: LED0=accepted PB0, LED1=accepted PB1 (debounced, 1 cycle latency from acceptance)
  - BLINK: LED0=LED1=phase
  - ALT: LED0=phase, LED1=~phase
- Reset mid-operation: all state returns to reset values immediately. No press event is generated on release after reset.
- A held button produces exactly one event regardless of hold time. There is no auto-repeat.

Optional Feature:
Macro PB_LED_DIM_EN.
- Defined: adds a 4-bit free-running PWM counter. In BLINK and ALT, the on-phase LED is driven high only while the PWM counter is < 4 (25% duty). MIRROR and OFF are unaffected.
- Undefined: no PWM counter is present and the on-phase LEDs are driven at full duty.

Decomposition:
- Package pb_led_pkg:
  - mode enum (OFF, MIRROR, BLINK, ALT) with 2-bit encoding
  - SPEED_MAX=2
  - PWM_ON_THRESH=4
- Sub-module pb_debounce (parameter DB_CYCLES; ports CLK, RST_n, pb_n, level, press), instantiated twice.
- Tick generator, FSM and LED output logic stay in the top module.

Test Plan:
All scenarios run with DB_CYCLES=4 and TICK_CYCLES=8.
1. Reset: assert RST_n=0 mid-BLINK -> LED0=LED1=0 and MODE=0 asynchronously; after release they stay 0 until a PB0 press.
2. Debounce: PB0_n low for 3 cycles, then high -> no MODE change. PB0_n low for 20 cycles -> MODE 0->1 exactly 6-7 cycles after the falling edge, and only once.
3. MIRROR: MODE=1, hold PB1_n low -> LED1=1 after 2+4+1 cycles, LED0=0. Release -> LED1=0 after the same latency.
4. BLINK speeds: MODE=2, speed 0 -> LED0 toggles every 8 cycles. One PB1 press -> every 16 cycles. Two more presses -> wraps to 8.
5. ALT plus simultaneous presses: MODE=2, press PB0 and PB1 within the same cycle -> MODE=3, speed unchanged, LED1=~LED0 always.
6. PB_LED_DIM_EN: with the macro defined, BLINK on-phase -> LED0 high 4 of every 16 cycles. Without the macro -> high 16 of 16.
